// File: rtl/simd_pkg.sv
// Shared constants, the buffered writeback entry type and the round-robin scan
// used by the SIMD writeback collector.
package simd_pkg;
  localparam int LANES      = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int RES_W      = 9;
  localparam int TAG_W      = 2;
  localparam int LANE_W     = $clog2(LANES);

  typedef struct packed {
    logic [RES_W-1:0] result;
    logic [TAG_W-1:0] tag;
  } wb_entry_t;

  // First requesting index at or after ptr, wrapping; returns ptr when none request.
  function automatic logic [LANE_W-1:0] rr_pick(input logic [LANES-1:0] req,
                                                input logic [LANE_W-1:0] ptr);
    logic [LANE_W-1:0] idx;
    rr_pick = ptr;
    for (int k = LANES - 1; k >= 0; k--) begin
      idx = LANE_W'((int'(ptr) + k) % LANES);
      if (req[idx]) rr_pick = idx;
    end
  endfunction
endpackage

// File: rtl/simd_wb_collector_if.sv
// Lane-result inputs and writeback bus of the collector; slave is the collector,
// master is the lane array plus writeback consumer.
interface simd_wb_collector_if;
  import simd_pkg::*;

  logic [LANES-1:0]            lane_valid;
  logic [LANES-1:0][RES_W-1:0] lane_result;
  logic [LANES-1:0][TAG_W-1:0] lane_tag;
  logic [LANES-1:0]            lane_ready;
  logic                        wb_valid;
  logic                        wb_ready;
  logic [RES_W-1:0]            wb_result;
  logic [LANE_W-1:0]           wb_lane;
  logic [TAG_W-1:0]            wb_tag;
  logic [LANES-1:0]            overflow;

  modport slave (
    input  lane_valid, lane_result, lane_tag, wb_ready,
    output lane_ready, wb_valid, wb_result, wb_lane, wb_tag, overflow
  );

  modport master (
    output lane_valid, lane_result, lane_tag, wb_ready,
    input  lane_ready, wb_valid, wb_result, wb_lane, wb_tag, overflow
  );
endinterface

// File: rtl/simd_result_fifo.sv
// Per-lane synchronous result FIFO; full/empty come from an extra pointer wrap bit.
module simd_result_fifo
  import simd_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output wb_entry_t dout,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  wb_entry_t   mem_q [DEPTH];
  logic        do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign wp_d    = wp_q + (AW+1)'(do_push);
  assign rp_d    = rp_q + (AW+1)'(do_pop);

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign dout  = mem_q[rp_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/simd_wb_collector.sv
// Buffers per-lane SIMD results in FIFOs and merges them round-robin onto one
// registered valid/ready writeback bus; drops into a full FIFO set sticky overflow.
module simd_wb_collector
  import simd_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  simd_wb_collector_if.slave bus
);
  logic [LANES-1:0]  full, empty, pop;
  wb_entry_t [LANES-1:0] din, dout;

  logic [LANE_W-1:0] rr_q, rr_d, grant;
  logic              load;
  logic              wb_valid_q, wb_valid_d;
  logic [RES_W-1:0]  wb_result_q, wb_result_d;
  logic [LANE_W-1:0] wb_lane_q, wb_lane_d;
  logic [TAG_W-1:0]  wb_tag_q, wb_tag_d;
  logic [LANES-1:0]  ovf_q, ovf_d;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign din[i] = '{result: bus.lane_result[i], tag: bus.lane_tag[i]};
    assign pop[i] = load && (grant == LANE_W'(i));

    simd_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (bus.lane_valid[i] && !full[i]),
      .pop   (pop[i]),
      .din   (din[i]),
      .dout  (dout[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  assign grant = rr_pick(~empty, rr_q);
  assign load  = (!wb_valid_q || bus.wb_ready) && !(&empty);
  assign ovf_d = ovf_q | (bus.lane_valid & full);

  always_comb begin
    wb_valid_d  = wb_valid_q;
    wb_result_d = wb_result_q;
    wb_lane_d   = wb_lane_q;
    wb_tag_d    = wb_tag_q;
    rr_d        = rr_q;
    if (load) begin
      wb_valid_d  = 1'b1;
      wb_result_d = dout[grant].result;
      wb_tag_d    = dout[grant].tag;
      wb_lane_d   = grant;
      rr_d        = (grant == LANE_W'(LANES - 1)) ? '0 : grant + 1'b1;
    end else if (bus.wb_ready) begin
      wb_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid_q  <= 1'b0;
      wb_result_q <= '0;
      wb_lane_q   <= '0;
      wb_tag_q    <= '0;
      rr_q        <= '0;
      ovf_q       <= '0;
    end else begin
      wb_valid_q  <= wb_valid_d;
      wb_result_q <= wb_result_d;
      wb_lane_q   <= wb_lane_d;
      wb_tag_q    <= wb_tag_d;
      rr_q        <= rr_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.lane_ready = ~full;
  assign bus.wb_valid   = wb_valid_q;
  assign bus.wb_result  = wb_result_q;
  assign bus.wb_lane    = wb_lane_q;
  assign bus.wb_tag     = wb_tag_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_simd_wb_collector.sv
// Bench for simd_wb_collector: directed table, hand-written corner sequences and
// randomized traffic against a queue-based reference model.
module tb_simd_wb_collector;
  import simd_pkg::*;

  logic clk;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  simd_wb_collector_if bus();

  simd_wb_collector dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       lv;
    logic [3:0][8:0]  res;
    logic [3:0][1:0]  tg;
    logic             rdy;
    logic             ev;
    logic [1:0]       el;
    logic [8:0]       er;
    logic [1:0]       et;
  } vec_t;

  typedef struct {
    logic [8:0] r;
    logic [1:0] t;
  } ent_t;

  vec_t tbl [10];

  // Reference model state
  ent_t       mq [4][$];
  logic       m_valid;
  logic [8:0] m_res;
  logic [1:0] m_lane;
  logic [1:0] m_tag;
  int         m_rr;
  logic [3:0] m_ovf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] lv, input logic [35:0] res, input logic [7:0] tg,
                              input logic rdy, input logic ev, input logic [1:0] el,
                              input logic [8:0] er, input logic [1:0] et);
    vec_t v;
    v.lv = lv; v.res = res; v.tg = tg; v.rdy = rdy;
    v.ev = ev; v.el = el; v.er = er; v.et = et;
    return v;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < 4; l++) mq[l].delete();
    m_valid = 1'b0; m_res = '0; m_lane = '0; m_tag = '0; m_rr = 0; m_ovf = '0;
  endtask

  // One clock edge of the writeback stage, from the behavioural rules.
  task automatic model_step(input logic [3:0] lv, input logic [3:0][8:0] res,
                            input logic [3:0][1:0] tg, input logic rdy);
    int   g;
    bit   was_full [4];
    ent_t e;
    g = -1;
    for (int l = 0; l < 4; l++) was_full[l] = (mq[l].size() == FIFO_DEPTH);
    if (!m_valid || rdy)
      for (int k = 0; k < 4; k++)
        if (g < 0 && mq[(m_rr + k) % 4].size() > 0) g = (m_rr + k) % 4;
    if (g >= 0) begin
      e = mq[g].pop_front();
      m_valid = 1'b1; m_res = e.r; m_tag = e.t; m_lane = 2'(g);
      m_rr = (g + 1) % 4;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    for (int l = 0; l < 4; l++)
      if (lv[l]) begin
        if (!was_full[l]) begin
          e.r = res[l]; e.t = tg[l];
          mq[l].push_back(e);
        end else m_ovf[l] = 1'b1;
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_rdy;
    int cnt0, cnt3;

    reset = 1'b1;
    bus.lane_valid = '0; bus.lane_result = '0; bus.lane_tag = '0; bus.wb_ready = 1'b0;

    // Directed table: four lanes at once, then a lone lane-2 result
    tbl[0] = mk(4'b1111, {9'd40, 9'd30, 9'd20, 9'd10}, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b1, 1'b0, 2'd0, 9'd0, 2'd0);
    tbl[1] = mk(4'b0000, 36'd0, 8'd0, 1'b1, 1'b1, 2'd0, 9'd10, 2'd0);
    tbl[2] = mk(4'b0000, 36'd0, 8'd0, 1'b1, 1'b1, 2'd1, 9'd20, 2'd1);
    tbl[3] = mk(4'b0000, 36'd0, 8'd0, 1'b1, 1'b1, 2'd2, 9'd30, 2'd2);
    tbl[4] = mk(4'b0000, 36'd0, 8'd0, 1'b1, 1'b1, 2'd3, 9'd40, 2'd3);
    tbl[5] = mk(4'b0000, 36'd0, 8'd0, 1'b1, 1'b0, 2'd0, 9'd0, 2'd0);
    tbl[6] = mk(4'b0100, {9'd0, 9'h1FE, 9'd0, 9'd0}, {2'd0, 2'd3, 2'd0, 2'd0}, 1'b1, 1'b0, 2'd0, 9'd0, 2'd0);
    tbl[7] = mk(4'b0000, 36'd0, 8'd0, 1'b1, 1'b1, 2'd2, 9'h1FE, 2'd3);
    tbl[8] = mk(4'b0000, 36'd0, 8'd0, 1'b1, 1'b0, 2'd0, 9'd0, 2'd0);
    tbl[9] = mk(4'b0000, 36'd0, 8'd0, 1'b1, 1'b0, 2'd0, 9'd0, 2'd0);

    // Reset state and quiet idle after release
    tick();
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_lane_ready", 32'(bus.lane_ready), 32'hF);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_wb_data", 32'({bus.wb_result, bus.wb_lane, bus.wb_tag}), 32'd0);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_wb_valid", 32'(bus.wb_valid), 32'd0);
      chk("idle_lane_ready", 32'(bus.lane_ready), 32'hF);
      chk("idle_overflow", 32'(bus.overflow), 32'd0);
    end

    for (int i = 0; i < 10; i++) begin
      bus.lane_valid = tbl[i].lv; bus.lane_result = tbl[i].res;
      bus.lane_tag = tbl[i].tg; bus.wb_ready = tbl[i].rdy;
      tick();
      chk($sformatf("tbl%0d_valid", i), 32'(bus.wb_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_lane", i), 32'(bus.wb_lane), 32'(tbl[i].el));
        chk($sformatf("tbl%0d_result", i), 32'(bus.wb_result), 32'(tbl[i].er));
        chk($sformatf("tbl%0d_tag", i), 32'(bus.wb_tag), 32'(tbl[i].et));
      end
      chk($sformatf("tbl%0d_ovf", i), 32'(bus.overflow), 32'd0);
    end

    // Backpressure: lane 1 pushes 6 while the consumer stalls
    bus.wb_ready = 1'b0; bus.lane_result = '0; bus.lane_tag = '0;
    for (int p = 1; p <= 6; p++) begin
      bus.lane_valid = 4'b0010; bus.lane_result[1] = 9'(p);
      chk($sformatf("bp_ready_p%0d", p), 32'(bus.lane_ready[1]), 32'(p < 6));
      tick();
      chk($sformatf("bp_ovf_p%0d", p), 32'(bus.overflow), (p == 6) ? 32'h2 : 32'h0);
      chk($sformatf("bp_valid_p%0d", p), 32'(bus.wb_valid), 32'(p >= 2));
      if (p >= 2) begin
        chk($sformatf("bp_hold_res_p%0d", p), 32'(bus.wb_result), 32'd1);
        chk($sformatf("bp_hold_lane_p%0d", p), 32'(bus.wb_lane), 32'd1);
      end
    end
    bus.lane_valid = '0; bus.wb_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      tick();
      chk($sformatf("bp_drain_valid%0d", k), 32'(bus.wb_valid), 32'd1);
      chk($sformatf("bp_drain_res%0d", k), 32'(bus.wb_result), 32'(k));
      chk($sformatf("bp_drain_lane%0d", k), 32'(bus.wb_lane), 32'd1);
      chk($sformatf("bp_drain_ovf%0d", k), 32'(bus.overflow), 32'h2);
    end
    tick();
    chk("bp_empty_valid", 32'(bus.wb_valid), 32'd0);
    chk("bp_sticky_ovf", 32'(bus.overflow), 32'h2);

    // Lone lane-3 result moves the pointer back to lane 0
    bus.lane_valid = 4'b1000; bus.lane_result[3] = 9'h0AA; bus.lane_tag[3] = 2'd1;
    tick();
    chk("l3_latency_valid", 32'(bus.wb_valid), 32'd0);
    bus.lane_valid = '0;
    tick();
    chk("l3_valid", 32'(bus.wb_valid), 32'd1);
    chk("l3_data", 32'({bus.wb_lane, bus.wb_result, bus.wb_tag}), 32'({2'd3, 9'h0AA, 2'd1}));
    tick();
    chk("l3_done_valid", 32'(bus.wb_valid), 32'd0);

    // Lanes 0 and 3 refilled whenever they can accept: alternate 0,3,0,3...
    cnt0 = 0; cnt3 = 0;
    for (int c = 0; c <= 8; c++) begin
      bus.lane_valid = {bus.lane_ready[3], 2'b00, bus.lane_ready[0]};
      bus.lane_result[0] = 9'(100 + cnt0); bus.lane_tag[0] = 2'd1;
      bus.lane_result[3] = 9'(200 + cnt3); bus.lane_tag[3] = 2'd2;
      tick();
      cnt0 += int'(bus.lane_valid[0]);
      cnt3 += int'(bus.lane_valid[3]);
      chk($sformatf("alt_valid%0d", c), 32'(bus.wb_valid), 32'(c >= 1));
      if (c >= 1) begin
        chk($sformatf("alt_lane%0d", c), 32'(bus.wb_lane), ((c - 1) % 2 == 0) ? 32'd0 : 32'd3);
        chk($sformatf("alt_res%0d", c), 32'(bus.wb_result),
            32'((((c - 1) % 2 == 0) ? 100 : 200) + (c - 1) / 2));
        chk($sformatf("alt_tag%0d", c), 32'(bus.wb_tag), ((c - 1) % 2 == 0) ? 32'd1 : 32'd2);
      end
    end

    // Reset while holding a writeback and with partially filled FIFOs
    bus.lane_valid = '0; bus.wb_ready = 1'b0;
    chk("mid_pre_valid", 32'(bus.wb_valid), 32'd1);
    chk("mid_pre_ovf", 32'(bus.overflow), 32'h2);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.wb_valid), 32'd0);
    chk("mid_rst_ovf", 32'(bus.overflow), 32'd0);
    chk("mid_rst_ready", 32'(bus.lane_ready), 32'hF);
    chk("mid_rst_result", 32'(bus.wb_result), 32'd0);
    tick();
    reset = 1'b0; bus.wb_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("post_rst_valid%0d", c), 32'(bus.wb_valid), 32'd0);
    end

    // Randomized traffic against the reference model
    reset = 1'b1;
    model_reset();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 800; c++) begin
      for (int l = 0; l < 4; l++) begin
        bus.lane_valid[l]  = ($urandom_range(0, 9) < 4);
        bus.lane_result[l] = 9'($urandom);
        bus.lane_tag[l]    = 2'($urandom);
      end
      bus.wb_ready = ($urandom_range(0, 9) < 5);
      for (int l = 0; l < 4; l++) exp_rdy[l] = (mq[l].size() < FIFO_DEPTH);
      chk("rnd_lane_ready", 32'(bus.lane_ready), 32'(exp_rdy));
      @(posedge clk);
      model_step(bus.lane_valid, bus.lane_result, bus.lane_tag, bus.wb_ready);
      #1;
      chk("rnd_valid", 32'(bus.wb_valid), 32'(m_valid));
      if (m_valid) begin
        chk("rnd_lane", 32'(bus.wb_lane), 32'(m_lane));
        chk("rnd_result", 32'(bus.wb_result), 32'(m_res));
        chk("rnd_tag", 32'(bus.wb_tag), 32'(m_tag));
      end
      chk("rnd_ovf", 32'(bus.overflow), 32'(m_ovf));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/simd_wb_collector.md
Name: simd_wb_collector

Overview:
- Writeback stage directly downstream of the SIMD lane array.
- Each lane presents a completed 9-bit result with a per-lane valid and an RS tag. The lanes cannot stall, so the block buffers results in per-lane FIFOs.
- Buffered results are merged round-robin onto a single valid/ready writeback bus.
- A lane result arriving when that lane's FIFO is full is dropped and flagged as an overflow error.

Parameters:
- LANES, 4, number of SIMD lanes.
- FIFO_DEPTH, 4, entries per lane FIFO; power of two, ≥2.
- RES_W, 9, result width (8-bit operand plus carry/borrow).
- TAG_W, 2, RS index tag width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- lane_valid  in  LANES  per-lane result valid; single-cycle pulse per result.
- lane_result  in  LANES x RES_W  per-lane result data.
- lane_tag  in  LANES x TAG_W  per-lane RS index of the result.
- lane_ready  out  LANES  per-lane FIFO not full; advisory only, lanes do not stall.
- wb_valid  out  1  writeback data valid.
- wb_ready  in  1  consumer accepts writeback.
- wb_result  out  RES_W  writeback result.
- wb_lane  out  $clog2(LANES)  source lane of wb_result.
- wb_tag  out  TAG_W  RS tag of wb_result.
- overflow  out  LANES  sticky per-lane drop flag.

Behaviour:
- Reset values (asynchronous):
  - wb_valid=0; wb_result, wb_lane, wb_tag = 0.
  - overflow=0; all FIFOs empty; rr_ptr=0.
  - lane_ready = all ones (combinational, derived from !full).
- Push:
  - lane i pushes {lane_result[i], lane_tag[i]} at a clock edge when lane_valid[i] && lane_ready[i].
  - lane_ready[i] depends only on current FIFO state, not on a same-cycle pop.
- Drop: lane_valid[i] && !lane_ready[i] → data discarded, overflow[i] set to 1; it stays set until reset.
- Output register:
  - Loads when (!wb_valid || wb_ready) and at least one FIFO is non-empty.
  - Otherwise wb_valid drops to 0 when wb_ready is seen with nothing pending.
- Hold rule: while wb_valid && !wb_ready, wb_result, wb_lane and wb_tag stay stable.
- Arbitration:
  - Select the first non-empty FIFO scanning from rr_ptr upward, wrapping modulo LANES.
  - On a load, pop the selected FIFO and set rr_ptr = (granted+1) mod LANES.
  - rr_ptr is unchanged when no load occurs.
- Latency:
  - A push at edge E is visible as wb_valid high after edge E+1, given a free output register and no competing lanes.
  - There is no push-to-output bypass.
- Throughput: one writeback per cycle with wb_ready held high.
- Same FIFO push and pop in one cycle: allowed when the FIFO is not full; occupancy is unchanged.
- Ordering: per-lane results are delivered in push order. Cross-lane ordering is defined only by the round-robin arbiter.
- Pointer wrap: FIFO read/write pointers wrap modulo FIFO_DEPTH; full/empty is decided by an extra wrap bit.
- Reset mid-operation: all buffered and in-flight results are discarded, including a held wb_valid.

Decomposition:
- simd_pkg holds:
  - the LANES and RES_W/TAG_W constants;
  - typedef struct packed wb_entry_t {result, tag};
  - a function for the round-robin next-index scan.
- One sub-module, simd_result_fifo:
  - synchronous FIFO of wb_entry_t, depth FIFO_DEPTH;
  - ports push, pop, din, dout, full, empty;
  - instantiated once per lane via generate.

Test Plan:
- Reset → wb_valid=0, lane_ready=4'b1111, overflow=4'b0000; deassert reset with no traffic → outputs unchanged for 10 cycles.
- Lane 2 pulses result 9'h1FE tag 2'd3, wb_ready=1 → wb_valid high for exactly one cycle, after edge E+1, with wb_lane=2, wb_result=9'h1FE, wb_tag=3.
- All four lanes pulse in the same cycle with results 10, 20, 30, 40 and tags 0..3, wb_ready=1 → four consecutive writebacks in lane order 0, 1, 2, 3.
- Backpressure, part 1: wb_ready=0, lane 1 pushes 6 results on back-to-back cycles.
  - Results 1–5 are stored: 1 in the output register, 4 in the FIFO.
  - lane_ready[1] is low at the 6th push; result 6 is dropped and overflow[1]=1.
  - wb_* is stable throughout.
- Backpressure, part 2: then raise wb_ready → results 1–5 are emitted in order and overflow[1] stays 1.
- Lanes 0 and 3 are refilled every cycle, wb_ready=1 → wb_lane alternates 0, 3, 0, 3 for 8 writebacks.
- Assert reset while wb_valid=1 and FIFOs are partially full → immediate wb_valid=0, overflow=0, and no stale data after reset release.
